// File: rtl/sap_reg_pkg.sv
// sap_reg_pkg: mode encodings and sequencer states for multi_mode_register
package sap_reg_pkg;
    localparam logic [2:0] MODE_HOLD   = 3'd0;
    localparam logic [2:0] MODE_INC    = 3'd1;
    localparam logic [2:0] MODE_DEC    = 3'd2;
    localparam logic [2:0] MODE_SHL    = 3'd3;
    localparam logic [2:0] MODE_SHR    = 3'd4;
    localparam logic [2:0] MODE_ROTL   = 3'd5;
    localparam logic [2:0] MODE_ROTR   = 3'd6;
    localparam logic [2:0] MODE_MSHIFT = 3'd7;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/multi_mode_register.sv
// multi_mode_register: load/arith/shift register with flags, bus enable and shift-by-N sequencer
module multi_mode_register
    import sap_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int AW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             nL,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in,
    input  logic             dir,
    input  logic [AW-1:0]    amt,
    input  logic             en_out,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] bus_out,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    state_t state, state_nx;
    logic [WIDTH-1:0] q_nx;
    logic [AW-1:0] cnt, cnt_nx, amt_sat;
    logic carry_nx, dir_q, dir_nx, done_nx;

    assign amt_sat = (amt > AW'(WIDTH)) ? AW'(WIDTH) : amt;
    assign bus_out = en_out ? q : '0;
    assign zero = (q == '0);
    assign busy = (state == SHIFT);

    always_comb begin
        q_nx = q;
        carry_nx = carry;
        state_nx = state;
        cnt_nx = cnt;
        dir_nx = dir_q;
        done_nx = 1'b0;
        if (state == SHIFT) begin
            q_nx = dir_q ? {1'b0, q[WIDTH-1:1]} : {q[WIDTH-2:0], 1'b0};
            carry_nx = dir_q ? q[0] : q[WIDTH-1];
            cnt_nx = cnt - AW'(1);
            if (cnt == AW'(1)) begin
                state_nx = IDLE;
                done_nx = 1'b1;
            end
        end else if (!nL) begin
            q_nx = d_in;
        end else begin
            case (mode)
                MODE_HOLD: ;
                MODE_INC:  {carry_nx, q_nx} = {1'b0, q} + (WIDTH + 1)'(1);
                MODE_DEC:  {carry_nx, q_nx} = {1'b0, q} - (WIDTH + 1)'(1);
                MODE_SHL:  {carry_nx, q_nx} = {q, ser_in};
                MODE_SHR:  {q_nx, carry_nx} = {ser_in, q};
                MODE_ROTL: {carry_nx, q_nx} = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROTR: {q_nx, carry_nx} = {q[0], q[WIDTH-1:1], q[0]};
                MODE_MSHIFT: begin
                    // an amount of zero completes immediately without entering SHIFT
                    cnt_nx = amt_sat;
                    dir_nx = dir;
                    done_nx = (amt_sat == '0);
                    state_nx = (amt_sat == '0) ? IDLE : SHIFT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
            carry <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            dir_q <= 1'b0;
            done <= 1'b0;
        end else begin
            q <= q_nx;
            carry <= carry_nx;
            state <= state_nx;
            cnt <= cnt_nx;
            dir_q <= dir_nx;
            done <= done_nx;
        end
    end
endmodule

// File: tb/tb_multi_mode_register.sv
// tb_multi_mode_register: directed vectors checked through an expectation queue
module tb_multi_mode_register;
  logic clk = 1'b0;
  logic clr, nL, ser_in, dir, en_out;
  logic [2:0] mode;
  logic [7:0] d_in;
  logic [3:0] amt;
  logic [7:0] q, bus_out;
  logic carry, zero, busy, done;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string nm;
    logic [19:0] v;
  } exp_t;
  exp_t sb[$];
  multi_mode_register #(.WIDTH(8)) dut (
    .clk(clk), .clr(clr), .nL(nL), .mode(mode), .d_in(d_in), .ser_in(ser_in),
    .dir(dir), .amt(amt), .en_out(en_out), .q(q), .bus_out(bus_out),
    .carry(carry), .zero(zero), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  initial begin
    exp_t e;
    logic [19:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = {q, bus_out, carry, zero, busy, done};
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL %s: got q=%h bus=%h c=%b z=%b busy=%b done=%b, want q=%h bus=%h c=%b z=%b busy=%b done=%b",
                   e.nm, act[19:12], act[11:4], act[3], act[2], act[1], act[0],
                   e.v[19:12], e.v[11:4], e.v[3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  task automatic drv(input logic c, input logic n, input logic [2:0] m, input logic [7:0] d,
                     input logic s, input logic dr, input logic [3:0] a, input logic en);
    clr = c; nL = n; mode = m; d_in = d; ser_in = s; dir = dr; amt = a; en_out = en;
  endtask
  task automatic tick(input string nm, input logic chk, input logic [7:0] eq,
                      input logic ec, input logic eb, input logic edn);
    @(posedge clk);
    #1;
    if (chk) begin
      sb.push_back('{nm, {eq, (en_out ? eq : 8'h00), ec, (eq == 8'h00), eb, edn}});
      checks++;
      if (q !== eq) begin
        failures++;
        $display("FAIL %s direct: q=%h want %h", nm, q, eq);
      end
      checks++;
      if (carry !== ec) begin
        failures++;
        $display("FAIL %s direct: carry=%b want %b", nm, carry, ec);
      end
      checks++;
      if ({busy, done} !== {eb, edn}) begin
        failures++;
        $display("FAIL %s direct: busy=%b done=%b want busy=%b done=%b", nm, busy, done, eb, edn);
      end
    end
    @(negedge clk);
    #1;
  endtask
  initial begin
    drv(1, 1, 0, 8'h00, 0, 0, 0, 1); tick("reset", 1, 8'h00, 0, 0, 0);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 1); tick("reset_release", 1, 8'h00, 0, 0, 0);
    drv(0, 0, 0, 8'hCC, 0, 0, 0, 0); tick("load_cc", 1, 8'hCC, 0, 0, 0);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 0); tick("hold_bus_off", 1, 8'hCC, 0, 0, 0);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 1); tick("hold_bus_on", 1, 8'hCC, 0, 0, 0);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 1); tick("hold_3", 1, 8'hCC, 0, 0, 0);
    drv(0, 0, 3'd5, 8'hFF, 0, 0, 0, 1); tick("load_ff_ignores_mode", 1, 8'hFF, 0, 0, 0);
    drv(0, 1, 3'd1, 8'h00, 0, 0, 0, 1); tick("inc_wrap", 1, 8'h00, 1, 0, 0);
    drv(0, 1, 3'd2, 8'h00, 0, 0, 0, 1); tick("dec_wrap", 1, 8'hFF, 1, 0, 0);
    drv(0, 0, 0, 8'h81, 0, 0, 0, 1); tick("load_keeps_carry", 1, 8'h81, 1, 0, 0);
    drv(0, 1, 3'd3, 8'h00, 0, 0, 0, 1); tick("shl", 1, 8'h02, 1, 0, 0);
    drv(0, 0, 0, 8'h01, 0, 0, 0, 1); tick("load_01", 1, 8'h01, 1, 0, 0);
    drv(0, 1, 3'd6, 8'h00, 0, 0, 0, 1); tick("rotr", 1, 8'h80, 1, 0, 0);
    drv(0, 1, 3'd1, 8'h00, 0, 0, 0, 1); tick("inc", 1, 8'h81, 0, 0, 0);
    drv(0, 1, 3'd4, 8'h00, 1, 0, 0, 1); tick("shr_ser1", 1, 8'hC0, 1, 0, 0);
    drv(0, 1, 3'd5, 8'h00, 0, 0, 0, 1); tick("rotl", 1, 8'h81, 1, 0, 0);
    drv(0, 1, 3'd2, 8'h00, 0, 0, 0, 1); tick("dec", 1, 8'h80, 0, 0, 0);
    drv(0, 0, 0, 8'hB4, 0, 0, 0, 1); tick("load_b4", 1, 8'hB4, 0, 0, 0);
    drv(0, 1, 3'd7, 8'h00, 0, 1, 4'd3, 1); tick("ms3_start", 1, 8'hB4, 0, 1, 0);
    drv(0, 0, 3'd1, 8'hFF, 0, 0, 4'd7, 1); tick("ms3_s1_load_ignored", 1, 8'h5A, 0, 1, 0);
    drv(0, 1, 3'd1, 8'h00, 0, 0, 0, 1); tick("ms3_s2", 1, 8'h2D, 0, 1, 0);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 1); tick("ms3_done", 1, 8'h16, 1, 0, 1);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 1); tick("ms3_after", 1, 8'h16, 1, 0, 0);
    drv(0, 1, 3'd7, 8'h00, 0, 1, 4'd0, 1); tick("ms0_done", 1, 8'h16, 1, 0, 1);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 1); tick("ms0_after", 1, 8'h16, 1, 0, 0);
    drv(0, 1, 3'd7, 8'h00, 0, 0, 4'd1, 1); tick("ms1_start", 1, 8'h16, 1, 1, 0);
    drv(0, 1, 3'd7, 8'h00, 0, 0, 4'd9, 1); tick("ms1_done", 1, 8'h2C, 0, 0, 1);
    drv(0, 1, 3'd7, 8'h00, 0, 0, 4'd9, 1); tick("ms9_start_on_done", 1, 8'h2C, 0, 1, 0);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 1); tick("ms9_s1", 1, 8'h58, 0, 1, 0);
    tick("ms9_s2", 1, 8'hB0, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick("ms9_mid", 0, 8'h00, 0, 0, 0);
    tick("ms9_done_sat8", 1, 8'h00, 0, 0, 1);
    tick("ms9_after", 1, 8'h00, 0, 0, 0);
    drv(0, 0, 0, 8'hF0, 0, 0, 0, 1); tick("load_f0", 1, 8'hF0, 0, 0, 0);
    drv(0, 1, 3'd7, 8'h00, 0, 0, 4'd5, 1); tick("ms5_start", 1, 8'hF0, 0, 1, 0);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 1); tick("ms5_s1", 1, 8'hE0, 1, 1, 0);
    drv(1, 1, 0, 8'h00, 0, 0, 0, 1); tick("ms5_clr_abort", 1, 8'h00, 0, 0, 0);
    drv(0, 1, 0, 8'h00, 0, 0, 0, 1); tick("abort_no_done", 1, 8'h00, 0, 0, 0);
    tick("abort_idle", 1, 8'h00, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_mode_register.md
# multi_mode_register

Parametrised successor to the SAP-1 8-bit load/hold register. Adds configurable width, single-cycle arithmetic and shift modes, carry/zero flags, a bus output enable, and a multi-cycle shift-by-N sequencer with busy/done handshake. Used for the accumulator, B and output registers of the widened SAP datapath; it drives the shared bus and feeds the adder/subtractor.

## Interface
- WIDTH, 8, data width (≥2)
- AW, $clog2(WIDTH+1), width of shift-amount input (derived, not overridden)
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- nL  in  1  load, active-low: d_in → q
- mode  in  3  operation select (see Operation)
- d_in  in  WIDTH  parallel load data
- ser_in  in  1  serial fill bit for single-cycle shl/shr
- dir  in  1  multi-shift direction: 0 left, 1 right (zero fill)
- amt  in  AW  multi-shift amount
- en_out  in  1  bus output enable
- q  out  WIDTH  register contents (always visible to adder)
- bus_out  out  WIDTH  q when en_out=1, else all zeros
- carry  out  1  registered carry/borrow/shifted-out bit
- zero  out  1  combinational, q==0
- busy  out  1  multi-shift in progress
- done  out  1  one-cycle pulse, multi-shift complete

## Operation
- Priority per edge: clr > busy sequencer > nL=0 load > mode.
- clr=1: q=0, carry=0, busy=0, done=0, FSM → IDLE; aborts any multi-shift.
- Load (nL=0, not busy): q=d_in, carry unchanged; mode ignored.
- Modes (nL=1, not busy): 000 hold; 001 inc (carry = carry-out); 010 dec (carry = borrow); 011 shl, ser_in → LSB, carry = old MSB; 100 shr, ser_in → MSB, carry = old LSB; 101 rotl; 110 rotr (rotates: carry = bit wrapped); 111 multi-shift start.
- Inc/dec wrap modulo 2^WIDTH: all-ones+1 → 0, carry=1; 0−1 → all-ones, carry=1.
- Multi-shift: start latches count = min(amt, WIDTH) and dir. FSM IDLE → SHIFT when count>0; each SHIFT edge shifts one bit (zero fill), carry = bit shifted out, count−1; at count→0 return to IDLE, done=1 for one cycle.
- amt=0: no shift, IDLE kept, done=1 next cycle, q/carry unchanged.
- While busy: nL, mode, d_in, amt, dir ignored; en_out still honoured.
- done never coincides with busy=1.

## Timing
- Load, inc/dec, single shifts/rotates: result visible on q one cycle after the sampling edge.
- Multi-shift of N (1..WIDTH): busy high exactly N cycles starting the cycle after start edge; done high the cycle after busy falls... precisely: done asserts on the edge performing the final shift, same edge busy deasserts.
- New command accepted on the edge where done=1 (back-to-back starts allowed).
- bus_out, zero combinational from q/en_out; no added latency.
- Reset values: q=0, bus_out=0, carry=0, zero=1, busy=0, done=0.

## Structure
- Package sap_reg_pkg: mode encodings (MODE_HOLD…MODE_MSHIFT), FSM state enum (IDLE, SHIFT).
- Single module; no sub-module. Shift/arith next-state as one combinational block, FSM and count in the same module.

## Test plan
- clr=1 then release, WIDTH=8 -> q=0x00, zero=1, carry=0, busy=0, done=0.
- nL=0, d_in=0xCC; then nL=1, mode=000 for 3 cycles -> q=0xCC held, en_out=0 gives bus_out=0x00, en_out=1 gives 0xCC.
- Load 0xFF, mode=001 -> q=0x00, carry=1, zero=1; then mode=010 -> q=0xFF, carry=1.
- Load 0x81, mode=011 ser_in=0 -> q=0x02, carry=1; mode=110 on 0x01 -> q=0x80, carry=1.
- Load 0xB4, mode=111 dir=1 amt=3 -> busy high 3 cycles, q=0x16, carry=1, done pulse one cycle; nL=0 mid-sequence ignored; amt=0 -> done next cycle, q unchanged.
- Multi-shift amt=5 with clr=1 on second busy cycle -> q=0, busy=0, no done pulse.
